// File: rtl/obi2axi_pkg.sv
// Shared types for the OBI-to-AXI-Lite bridge: FSM state encoding and AXI response codes.
package obi2axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    OBI_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/obi2axi.sv
// OBI responder to AXI-Lite manager bridge, one transaction in flight at a time.
// Define OBI2AXI_ERR_EN to report SLVERR/DECERR responses on err_o.
module obi2axi
  import obi2axi_pkg::*;
#(
  parameter int WordSize             = 32,
  parameter int AddrSize             = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 32
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic                              we_i,
  input  logic [3:0]                        be_i,
  input  logic [AddrSize-1:0]               addr_i,
  input  logic [WordSize-1:0]               wdata_i,
  output logic                              rvalid_o,
  output logic [WordSize-1:0]               rdata_o,
  output logic                              err_o,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  if (C_M00_AXI_DATA_WIDTH != WordSize) begin : g_dataWidthCheck
    $error("obi2axi: C_M00_AXI_DATA_WIDTH must equal WordSize");
  end
  if (C_M00_AXI_ADDR_WIDTH != AddrSize) begin : g_addrWidthCheck
    $error("obi2axi: C_M00_AXI_ADDR_WIDTH must equal AddrSize");
  end

  state_t                 r_state;
  state_t                 w_nextState;
  logic [AddrSize-1:0]    r_addr;
  logic [WordSize-1:0]    r_wdata;
  logic [WordSize-1:0]    r_rdata;
  logic [3:0]             r_be;
  logic                   r_we;
  logic                   r_awDone;
  logic                   r_wDone;
  logic                   w_awFire;
  logic                   w_wFire;

  // Address and data channels of a write complete independently, so each
  // valid drops on its own handshake while the state waits for both.
  assign m00_axi_awvalid = (r_state == WR_REQ) && !r_awDone;
  assign m00_axi_wvalid  = (r_state == WR_REQ) && !r_wDone;
  assign m00_axi_bready  = (r_state == WR_RESP);
  assign m00_axi_arvalid = (r_state == RD_REQ);
  assign m00_axi_rready  = (r_state == RD_DATA);
  assign w_awFire        = m00_axi_awvalid && m00_axi_awready;
  assign w_wFire         = m00_axi_wvalid && m00_axi_wready;

  assign m00_axi_awaddr  = r_addr;
  assign m00_axi_araddr  = r_addr;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = r_be;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_arprot  = 3'b000;

  // Grant is masked by reset so it cannot follow req_i while the bridge is held.
  assign gnt_o    = (r_state == IDLE) && req_i && !m00_axi_areset;
  assign rvalid_o = (r_state == OBI_RESP);
  assign rdata_o  = (rvalid_o && !r_we) ? r_rdata : '0;

`ifdef OBI2AXI_ERR_EN
  logic [1:0] r_resp;
  // Bit 1 of the AXI response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign err_o = rvalid_o && r_resp[1];

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      r_resp <= RESP_OKAY;
    end else if ((r_state == WR_RESP) && m00_axi_bvalid) begin
      r_resp <= m00_axi_bresp;
    end else if ((r_state == RD_DATA) && m00_axi_rvalid) begin
      r_resp <= m00_axi_rresp;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{m00_axi_bresp, m00_axi_rresp};
  assign err_o    = 1'b0;
`endif

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (req_i) w_nextState = we_i ? WR_REQ : RD_REQ;
      WR_REQ:   if ((r_awDone || w_awFire) && (r_wDone || w_wFire)) w_nextState = WR_RESP;
      WR_RESP:  if (m00_axi_bvalid) w_nextState = OBI_RESP;
      RD_REQ:   if (m00_axi_arready) w_nextState = RD_DATA;
      RD_DATA:  if (m00_axi_rvalid) w_nextState = OBI_RESP;
      OBI_RESP: w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
      r_awDone <= 1'b0;
      r_wDone  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && req_i) begin
        r_addr   <= addr_i;
        r_wdata  <= wdata_i;
        r_be     <= be_i;
        r_we     <= we_i;
        r_awDone <= 1'b0;
        r_wDone  <= 1'b0;
      end
      if (w_awFire) r_awDone <= 1'b1;
      if (w_wFire) r_wDone <= 1'b1;
      if ((r_state == RD_DATA) && m00_axi_rvalid) r_rdata <= m00_axi_rdata;
    end
  end

endmodule

// File: doc/obi2axi.md
OBI2AXI -- requirements
Module: obi2axi

Interface
REQ-001 SHALL have parameter WordSize, default 32, OBI data width.
REQ-002 SHALL have parameter AddrSize, default 32, OBI address width.
REQ-003 SHALL have parameter C_M00_AXI_DATA_WIDTH, default 32, AXI-Lite data width; must equal WordSize.
REQ-004 SHALL have parameter C_M00_AXI_ADDR_WIDTH, default 32, AXI-Lite address width; must equal AddrSize.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: m00_axi_aclk input 1 (clock), m00_axi_areset input 1 (reset).
REQ-006 SHALL have OBI responder ports: req_i in 1; gnt_o out 1; we_i in 1; be_i in 4; addr_i in AddrSize; wdata_i in WordSize; rvalid_o out 1; rdata_o out WordSize; err_o out 1.
REQ-007 SHALL have AXI-Lite write-address ports: m00_axi_awaddr out ADDR_WIDTH; m00_axi_awprot out 3; m00_axi_awvalid out 1; m00_axi_awready in 1.
REQ-008 SHALL have write-data ports: m00_axi_wdata out DATA_WIDTH; m00_axi_wstrb out DATA_WIDTH/8; m00_axi_wvalid out 1; m00_axi_wready in 1.
REQ-009 SHALL have write-response ports: m00_axi_bresp in 2; m00_axi_bvalid in 1; m00_axi_bready out 1.
REQ-010 SHALL have read ports: m00_axi_araddr out ADDR_WIDTH; m00_axi_arprot out 3; m00_axi_arvalid out 1; m00_axi_arready in 1; m00_axi_rdata in DATA_WIDTH; m00_axi_rresp in 2; m00_axi_rvalid in 1; m00_axi_rready out 1.

Function
REQ-011 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, OBI_RESP; exactly one transaction outstanding.
REQ-012 SHALL, in IDLE only, assert gnt_o combinationally when req_i=1, and latch addr_i, wdata_i, be_i, we_i that cycle; next state WR_REQ if we_i else RD_REQ.
REQ-013 SHALL hold gnt_o=0 in every state except IDLE.
REQ-014 SHALL, in WR_REQ, assert awvalid and wvalid together; each drops independently after its own valid&ready cycle; leave to WR_RESP once both handshakes are done (same or different cycles).
REQ-015 SHALL, in WR_RESP, assert bready=1; on bvalid capture bresp, go to OBI_RESP.
REQ-016 SHALL, in RD_REQ, assert arvalid until arready; then RD_DATA.
REQ-017 SHALL, in RD_DATA, assert rready=1; on rvalid capture rdata and rresp, go to OBI_RESP.
REQ-018 SHALL, in OBI_RESP, assert rvalid_o for exactly one cycle, then return to IDLE; rdata_o=captured read data for reads, 0 for writes.
REQ-019 SHALL drive awaddr/araddr from the latched address, wdata from latched wdata, wstrb from latched be, awprot=arprot=3'b000.
REQ-020 SHALL keep AXI address/data outputs stable while the corresponding valid is high.
REQ-021 SHALL give minimum latency gnt->rvalid_o of 3 cycles (read and write) with zero-wait AXI slave.
REQ-022 SHALL never deassert an AXI valid before its handshake; stalls of any length on ready/bvalid/rvalid are permitted.

Reset
REQ-023 SHALL, on m00_axi_areset=1, immediately (asynchronously) enter IDLE, clear all latched registers to 0, and drive all outputs 0, aborting any in-flight transaction.
REQ-024 SHALL accept a new req_i in the first cycle after reset release.

Configuration
REQ-025 SHALL, with OBI2AXI_ERR_EN defined, assert err_o together with rvalid_o when captured bresp/rresp is SLVERR (2'b10) or DECERR (2'b11).
REQ-026 SHALL, without OBI2AXI_ERR_EN, keep the err_o port and tie it to 0; responses are ignored.

Structure
REQ-027 SHALL place state_t enum and AXI response constants (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR) in package obi2axi_pkg.
REQ-028 SHALL be a single module with no sub-modules; width-mismatch parameters shall be rejected by an elaboration-time assertion.

Verification
REQ-029 Read, zero-wait slave: req_i=1, we_i=0, addr_i=0x1000_0004, slave rdata=0xDEAD_BEEF -> gnt same cycle, araddr=0x1000_0004, rvalid_o 3 cycles after gnt with rdata_o=0xDEAD_BEEF.
REQ-030 Write, awready 4 cycles after wready: addr_i=0x2000_0000, wdata_i=0x1234_5678, be_i=4'b0011 -> wvalid drops after its handshake, awvalid held, wstrb=4'b0011, one rvalid_o pulse after bvalid.
REQ-031 Back-to-back: req_i held high for two reads -> second gnt only in cycle after first rvalid_o returns to IDLE; gnt_o=0 throughout.
REQ-032 Error, OBI2AXI_ERR_EN defined: rresp=2'b10 -> err_o=1 with rvalid_o; same test without macro -> err_o=0.
REQ-033 Reset during RD_DATA with rvalid stalled: assert m00_axi_areset -> arvalid, rready, rvalid_o, gnt_o 0 immediately; post-release read completes normally.
